prog_prio_grant_scheduler: RTL and testbench

Sequential 4-requester scheduler built around a programmable fixed-priority decision. It holds the grant for the owner's whole transaction, ends it on `done`, on request drop or on a hold-time limit, and inserts one idle cycle between grants. A shadow/active priority register keeps reconfiguration glitch-free. It sits in front of a shared resource, for example a bus or memory port, that the 4 requesters contend for.

---
 rtl/prog_prio_grant_scheduler_if.sv | 29 ++
 rtl/prog_prio_grant_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_prog_prio_grant_scheduler.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_prio_grant_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : prog_prio_grant_scheduler_if
// Brief   : Request/grant and priority-configuration bundle between the
//           requesters and the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface prog_prio_grant_scheduler_if;
    logic [3:0] req;
    logic [3:0] done;
    logic       cfg_we;
    logic [7:0] cfg_prio;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;
    logic       cfg_pend;

    modport master (
        output req, done, cfg_we, cfg_prio,
        input  grant, grant_id, busy, timeout, cfg_pend
    );

    modport slave (
        input  req, done, cfg_we, cfg_prio,
        output grant, grant_id, busy, timeout, cfg_pend
    );
endinterface
`default_nettype wire

// File: rtl/prog_prio_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : prog_prio_grant_scheduler
// Brief   : 4-requester programmable fixed-priority scheduler with held,
//           non-preemptive grants, hold-time limit and shadowed priority.
//           Optional starvation aging enabled by macro AGING_BOOST_EN.
// Revision: 1.0 - initial release
// ============================================================================
module prog_prio_grant_scheduler #(
    parameter int unsigned MAX_HOLD  = 8,
    parameter int unsigned AGE_LIMIT = 3
) (
    input wire                          clk,
    input wire                          rst,
    prog_prio_grant_scheduler_if.slave  bus
);

    localparam logic       c_ST_IDLE  = 1'b0;
    localparam logic       c_ST_GRANT = 1'b1;
    localparam logic [7:0] c_PRIO_RST = 8'b11_10_01_00;
    localparam logic [7:0] c_MAX_HOLD = 8'(MAX_HOLD);

    // The 2-bit age counter saturates at 3, so a larger limit could never boost.
    if (MAX_HOLD < 1 || MAX_HOLD > 255 || AGE_LIMIT > 3) begin : g_param_check
        $error("prog_prio_grant_scheduler: MAX_HOLD or AGE_LIMIT out of range");
    end

    logic       r_state;
    logic [3:0] r_grant;
    logic [1:0] r_grant_id;
    logic       r_busy;
    logic       r_timeout;
    logic       r_cfg_pend;
    logic [7:0] r_hold_cnt;
    logic [7:0] r_active_prio;
    logic [7:0] r_shadow_prio;

    logic       w_state_nxt;
    logic [3:0] w_grant_nxt;
    logic [1:0] w_grant_id_nxt;
    logic       w_busy_nxt;
    logic       w_timeout_nxt;
    logic       w_cfg_pend_nxt;
    logic [7:0] w_hold_cnt_nxt;
    logic [7:0] w_active_nxt;
    logic [7:0] w_shadow_nxt;
    logic       w_issue;

    logic       w_win_vld;
    logic [1:0] w_win_id;
    logic [1:0] w_best_rank;
    logic [3:0] w_boost;

`ifdef AGING_BOOST_EN
    logic [1:0] r_age [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_boost[i] = bus.req[i] && ({30'd0, r_age[i]} >= AGE_LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_age[i] <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.req[i] || (w_issue && w_win_id == 2'(i))) begin
                    r_age[i] <= 2'd0;
                end else if (w_issue && r_age[i] != 2'd3) begin
                    r_age[i] <= r_age[i] + 2'd1;
                end
            end
        end
    end
`else
    assign w_boost = 4'b0000;
`endif

    // Strict less-than on an ascending scan gives ties to the lower index.
    always_comb begin
        w_win_vld   = 1'b0;
        w_win_id    = 2'd0;
        w_best_rank = 2'd3;
        for (int i = 0; i < 4; i++) begin
            if (bus.req[i] && (!w_win_vld || r_active_prio[2*i +: 2] < w_best_rank)) begin
                w_win_vld   = 1'b1;
                w_win_id    = 2'(i);
                w_best_rank = r_active_prio[2*i +: 2];
            end
        end
        if (|w_boost) begin
            for (int i = 3; i >= 0; i--) begin
                if (w_boost[i]) w_win_id = 2'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_busy_nxt     = r_busy;
        w_timeout_nxt  = 1'b0;
        w_cfg_pend_nxt = r_cfg_pend;
        w_hold_cnt_nxt = r_hold_cnt;
        w_active_nxt   = r_active_prio;
        w_shadow_nxt   = r_shadow_prio;
        w_issue        = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (r_cfg_pend) begin
                    w_active_nxt   = r_shadow_prio;
                    w_cfg_pend_nxt = 1'b0;
                end else if (w_win_vld) begin
                    w_state_nxt    = c_ST_GRANT;
                    w_grant_nxt    = 4'b0001 << w_win_id;
                    w_grant_id_nxt = w_win_id;
                    w_busy_nxt     = 1'b1;
                    w_hold_cnt_nxt = 8'd1;
                    w_issue        = 1'b1;
                end
            end
            c_ST_GRANT: begin
                if (bus.done[r_grant_id] || !bus.req[r_grant_id]) begin
                    w_state_nxt = c_ST_IDLE;
                    w_grant_nxt = 4'b0000;
                    w_busy_nxt  = 1'b0;
                end else if (r_hold_cnt == c_MAX_HOLD) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_grant_nxt   = 4'b0000;
                    w_busy_nxt    = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // A write landing on the load edge stays pending for the next idle cycle.
        if (bus.cfg_we) begin
            w_shadow_nxt   = bus.cfg_prio;
            w_cfg_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_grant       <= 4'b0000;
            r_grant_id    <= 2'd0;
            r_busy        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cfg_pend    <= 1'b0;
            r_hold_cnt    <= 8'd0;
            r_active_prio <= c_PRIO_RST;
            r_shadow_prio <= c_PRIO_RST;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_busy        <= w_busy_nxt;
            r_timeout     <= w_timeout_nxt;
            r_cfg_pend    <= w_cfg_pend_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_active_prio <= w_active_nxt;
            r_shadow_prio <= w_shadow_nxt;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = r_busy;
    assign bus.timeout  = r_timeout;
    assign bus.cfg_pend = r_cfg_pend;

endmodule
`default_nettype wire

// File: tb/tb_prog_prio_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_prio_grant_scheduler
// Brief   : Directed bench for prog_prio_grant_scheduler with a behavioural
//           reference model compared every cycle, plus literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prog_prio_grant_scheduler;

    localparam int         c_MAX_HOLD  = 8;
    localparam int         c_AGE_LIMIT = 3;
    localparam logic [7:0] c_PRIO_DEF  = 8'b11_10_01_00;
    localparam logic [7:0] c_PRIO_A    = 8'b01_11_00_10;
    localparam logic [7:0] c_PRIO_B    = 8'b00_01_10_11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   cmp_en = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    prog_prio_grant_scheduler_if bus_if ();

    prog_prio_grant_scheduler #(
        .MAX_HOLD  (c_MAX_HOLD),
        .AGE_LIMIT (c_AGE_LIMIT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: owner / held-cycle view of the scheduler
    bit       m_busy;
    int       m_owner;
    int       m_held;
    bit       m_tmo;
    bit [7:0] m_active;
    bit [7:0] m_shadow;
    bit       m_pend;
    int       m_age [4];

    function automatic int rank_of(input int i);
        return int'((m_active >> (2 * i)) & 8'd3);
    endfunction

    // Smallest key wins: boosted requesters sort below every ranked one.
    function automatic int pick(input logic [3:0] r);
        int best, best_key, key;
        best = -1;
        best_key = 1000;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) begin
                key = 16 + rank_of(i) * 4 + i;
`ifdef AGING_BOOST_EN
                if (m_age[i] >= c_AGE_LIMIT) key = i;
`endif
                if (key < best_key) begin
                    best_key = key;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin : model
        int w;
        bit issued;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_held = 0; m_tmo = 0;
            m_active = c_PRIO_DEF; m_shadow = c_PRIO_DEF; m_pend = 0;
            for (int i = 0; i < 4; i++) m_age[i] = 0;
        end else begin
            w = -1;
            issued = 0;
            m_tmo = 0;
            if (!m_busy) begin
                if (m_pend) begin
                    m_active = m_shadow;
                    m_pend = 0;
                end else begin
                    w = pick(bus_if.req);
                    if (w >= 0) begin
                        m_busy = 1; m_owner = w; m_held = 1; issued = 1;
                    end
                end
            end else if (bus_if.done[m_owner] || !bus_if.req[m_owner]) begin
                m_busy = 0;
            end else if (m_held == c_MAX_HOLD) begin
                m_busy = 0;
                m_tmo = 1;
            end else begin
                m_held++;
            end
            for (int i = 0; i < 4; i++) begin
                if (!bus_if.req[i] || (issued && w == i)) m_age[i] = 0;
                else if (issued && m_age[i] < 3) m_age[i]++;
            end
            if (bus_if.cfg_we) begin
                m_shadow = bus_if.cfg_prio;
                m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_grant",    {28'd0, bus_if.grant},    m_busy ? (32'd1 << m_owner) : 32'd0);
            chk("model_grant_id", {30'd0, bus_if.grant_id}, 32'(m_owner));
            chk("model_busy",     {31'd0, bus_if.busy},     {31'd0, m_busy});
            chk("model_timeout",  {31'd0, bus_if.timeout},  {31'd0, m_tmo});
            chk("model_cfg_pend", {31'd0, bus_if.cfg_pend}, {31'd0, m_pend});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic t, input logic p);
        chk({tag, "_grant"},    {28'd0, bus_if.grant},    {28'd0, g});
        chk({tag, "_timeout"},  {31'd0, bus_if.timeout},  {31'd0, t});
        chk({tag, "_cfg_pend"}, {31'd0, bus_if.cfg_pend}, {31'd0, p});
    endtask

    initial begin
        bus_if.req = 4'b0000;
        bus_if.done = 4'b0000;
        bus_if.cfg_we = 1'b0;
        bus_if.cfg_prio = 8'h00;
        step();
        step();
        cmp_en = 1'b1;
        expect_out("reset", 4'b0000, 1'b0, 1'b0);
        chk("reset_busy", {31'd0, bus_if.busy}, 32'd0);
        rst = 1'b0;

        // Write coinciding with the shadow-to-active load keeps cfg_pend high
        bus_if.cfg_we = 1'b1; bus_if.cfg_prio = c_PRIO_A;
        step();
        expect_out("cfgw1", 4'b0000, 1'b0, 1'b1);
        bus_if.cfg_prio = c_PRIO_DEF;
        step();
        expect_out("cfg_coincide", 4'b0000, 1'b0, 1'b1);
        bus_if.cfg_we = 1'b0;
        step();
        expect_out("cfg_settle", 4'b0000, 1'b0, 1'b0);

        // Default order, all requesting, R0 re-granted after one idle cycle
        bus_if.req = 4'b1111;
        step();
        expect_out("r0_first", 4'b0001, 1'b0, 1'b0);
        chk("r0_first_id", {30'd0, bus_if.grant_id}, 32'd0);
        bus_if.done = 4'b0001;
        step();
        expect_out("r0_gap", 4'b0000, 1'b0, 1'b0);
        bus_if.done = 4'b0000;
        step();
        expect_out("r0_again", 4'b0001, 1'b0, 1'b0);
        bus_if.req = 4'b1110;
        step();
        for (int k = 1; k < 4; k++) begin
            step();
            expect_out($sformatf("rr_r%0d", k), 4'(1 << k), 1'b0, 1'b0);
            bus_if.done = 4'(1 << k);
            bus_if.req = bus_if.req & ~4'(1 << k);
            step();
            expect_out($sformatf("rr_gap%0d", k), 4'b0000, 1'b0, 1'b0);
            bus_if.done = 4'b0000;
        end

        // Reprogrammed order: R1(00) > R3(01) > R0(10) > R2(11)
        bus_if.cfg_we = 1'b1; bus_if.cfg_prio = c_PRIO_A;
        step();
        expect_out("cfgA_pend", 4'b0000, 1'b0, 1'b1);
        bus_if.cfg_we = 1'b0; bus_if.req = 4'b1111;
        step();
        expect_out("cfgA_stall", 4'b0000, 1'b0, 1'b0);
        step();
        expect_out("cfgA_all", 4'b0010, 1'b0, 1'b0);
        bus_if.done = 4'b0010; bus_if.req = 4'b1101;
        step();
        bus_if.done = 4'b0000;
        step();
        expect_out("cfgA_1101", 4'b1000, 1'b0, 1'b0);
        bus_if.done = 4'b1000; bus_if.req = 4'b0011;
        step();
        bus_if.done = 4'b0000;
        step();
        expect_out("cfgA_0011", 4'b0010, 1'b0, 1'b0);
        bus_if.done = 4'b0010; bus_if.req = 4'b0000;
        step();
        bus_if.done = 4'b0000;

        // Write while granted: deferred until release, then one stall cycle
        bus_if.req = 4'b0001;
        step();
        expect_out("busyw_grant", 4'b0001, 1'b0, 1'b0);
        bus_if.cfg_we = 1'b1; bus_if.cfg_prio = c_PRIO_B;
        step();
        expect_out("busyw_pend", 4'b0001, 1'b0, 1'b1);
        bus_if.cfg_we = 1'b0; bus_if.req = 4'b1111;
        step();
        expect_out("busyw_nopreempt", 4'b0001, 1'b0, 1'b1);
        bus_if.done = 4'b0001; bus_if.req = 4'b1110;
        step();
        expect_out("busyw_release", 4'b0000, 1'b0, 1'b1);
        bus_if.done = 4'b0000;
        step();
        expect_out("busyw_stall", 4'b0000, 1'b0, 1'b0);
        step();
        expect_out("busyw_neworder", 4'b1000, 1'b0, 1'b0);
        bus_if.done = 4'b1000; bus_if.req = 4'b0000;
        step();
        bus_if.done = 4'b0000;

        // Back to default order, then R1 runs into the hold limit
        bus_if.cfg_we = 1'b1; bus_if.cfg_prio = c_PRIO_DEF;
        step();
        bus_if.cfg_we = 1'b0;
        step();
        bus_if.req = 4'b0010;
        for (int c = 1; c <= c_MAX_HOLD; c++) begin
            step();
            expect_out($sformatf("hold_c%0d", c), 4'b0010, 1'b0, 1'b0);
        end
        step();
        expect_out("hold_timeout", 4'b0000, 1'b1, 1'b0);
        step();
        expect_out("hold_regrant", 4'b0010, 1'b0, 1'b0);

        // Owner drops req on the same edge the limit is reached: no timeout
        for (int c = 2; c <= c_MAX_HOLD; c++) step();
        bus_if.req = 4'b0000;
        step();
        expect_out("drop_at_limit", 4'b0000, 1'b0, 1'b0);

        // Reset mid-grant, overriding a concurrent config write
        bus_if.req = 4'b0100;
        step();
        expect_out("pre_rst", 4'b0100, 1'b0, 1'b0);
        chk("pre_rst_id", {30'd0, bus_if.grant_id}, 32'd2);
        rst = 1'b1; bus_if.cfg_we = 1'b1; bus_if.cfg_prio = c_PRIO_B;
        step();
        expect_out("mid_rst", 4'b0000, 1'b0, 1'b0);
        chk("mid_rst_id", {30'd0, bus_if.grant_id}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus_if.busy}, 32'd0);
        rst = 1'b0; bus_if.cfg_we = 1'b0; bus_if.req = 4'b0000;
        step();

        // R0 keeps re-requesting while R3 waits
        bus_if.req = 4'b1001;
        for (int g = 0; g < 3; g++) begin
            step();
            expect_out($sformatf("age_r0_%0d", g), 4'b0001, 1'b0, 1'b0);
            bus_if.done = 4'b0001;
            step();
            bus_if.done = 4'b0000;
        end
        step();
`ifdef AGING_BOOST_EN
        expect_out("age_fourth", 4'b1000, 1'b0, 1'b0);
`else
        expect_out("age_fourth", 4'b0001, 1'b0, 1'b0);
`endif
        bus_if.done = 4'b1001; bus_if.req = 4'b0000;
        step();
        bus_if.done = 4'b0000;
        step();
        step();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
